blake2s_block_loader: RTL

BLAKE2S_BLOCK_LOADER -- requirements
Module: blake2s_block_loader

---
 rtl/blake2_pkg.sv | 8 +
 rtl/blake2s_block_loader.sv | 87 ++++++++
 2 files changed

// File: rtl/blake2_pkg.sv
// blake2_pkg: shared widths and loader state encoding for the BLAKE2s block loader.
package blake2_pkg;
    localparam int WW = 32;
    localparam int NW = 16;
    localparam int BW = WW * NW;
    localparam int CW = 64;
    typedef enum logic {FILL, FULL} state_t;
endpackage

// File: rtl/blake2s_block_loader.sv
// blake2s_block_loader: packs message words into BLAKE2s blocks with byte count t_o and final flag.
// Define BLAKE2_LOADER_ERR_EN to add the sticky err_o checker on bytes_i misuse.
module blake2s_block_loader #(
    parameter int WW = blake2_pkg::WW,
    parameter int NW = blake2_pkg::NW
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [WW-1:0]            data_i,
    input  logic                     last_i,
    input  logic [2:0]               bytes_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [WW*NW-1:0]         block_o,
    output logic [blake2_pkg::CW-1:0] t_o,
    output logic                     final_o
`ifdef BLAKE2_LOADER_ERR_EN
    ,
    output logic                     err_o
`endif
);
    import blake2_pkg::*;

    localparam int IW = $clog2(NW);

    state_t          state, nxt;
    logic [IW-1:0]   widx;
    logic [CW-1:0]   cnt;
    logic [WW*NW-1:0] blk;
    logic            fin;
    logic [WW-1:0]   word;
    logic            acc, take, close;

    assign ready_o = state == FILL;
    assign valid_o = state == FULL;
    assign acc     = ready_o && valid_i;
    assign take    = valid_o && ready_i;
    assign close   = last_i || widx == IW'(NW - 1);
    assign block_o = blk;
    assign t_o     = cnt;
    assign final_o = fin;

    // Bytes at or beyond bytes_i in the closing word are padding and must read as zero.
    always_comb begin
        word = data_i;
        for (int b = 0; b < WW / 8; b++)
            if (last_i && b >= int'(bytes_i)) word[8*b +: 8] = 8'h00;
    end

    always_comb begin
        nxt = state;
        if (acc && close) nxt = FULL;
        else if (take) nxt = FILL;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= FILL;
        else state <= nxt;

    // Unwritten slots stay zero because the block register is cleared on every hand-off.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blk  <= '0;
            widx <= '0;
            cnt  <= '0;
            fin  <= 1'b0;
        end else if (acc) begin
            blk[widx*WW +: WW] <= word;
            widx <= widx + IW'(1);
            cnt  <= cnt + (last_i ? CW'(bytes_i) : CW'(4));
            fin  <= last_i;
        end else if (take) begin
            blk  <= '0;
            widx <= '0;
            fin  <= 1'b0;
            if (fin) cnt <= '0;
        end
    end

`ifdef BLAKE2_LOADER_ERR_EN
    always_ff @(posedge clk or posedge reset)
        if (reset) err_o <= 1'b0;
        else if (acc && ((!last_i && bytes_i != 3'd4) || bytes_i > 3'd4)) err_o <= 1'b1;
`endif
endmodule
